note_seq_ctrl: RTL and testbench
================================

# note_seq_ctrl

Record/playback sequencer for the guitar note datapath. It turns debounced select/back keys and the tempo tick from the clock divider into RAM address, write-enable and latch control for the 64x32 note RAM. It records one note slot per beat and plays back the recorded length. It sits between the top-level key/switch logic and the datapath, replacing ad-hoc address counting inside the datapath.

## Interface
- DEPTH, 64, note RAM depth in slots
- ADDR_W, 6, RAM address width; must satisfy 2^ADDR_W = DEPTH
- clk  in  1  system clock, 50 MHz
- resetn  in  1  reset, synchronous, active-low
- tick  in  1  one-cycle beat pulse from clock divider; consecutive ticks are ≥4 cycles apart
- select  in  1  debounced level, active-high
- back  in  1  debounced level, active-high
- mode_sel  in  1  0 = record, 1 = play; sampled only in IDLE on select press
- ram_addr  out  ADDR_W  RAM address, registered
- ram_wren  out  1  RAM write enable, one-cycle pulse
- latch_en  out  1  datapath accumulates string/fret inputs while high
- latch_clr  out  1  clears the datapath accumulator at the next edge
- note_strobe  out  1  play: RAM q at ram_addr is valid this cycle
- length  out  ADDR_W+1  number of recorded slots, 0..DEPTH
- busy  out  1  high in REC_ARM, RECORDING and PLAY
- done  out  1  one-cycle pulse on normal completion

## Operation
- Key edges: sel_rise = select & ~select_q and back_rise = back & ~back_q, using internal one-cycle delays. All key actions use the edges only, so a held key does not re-trigger.
- States: IDLE, REC_ARM, RECORDING, PLAY.
- IDLE:
  - sel_rise with mode_sel=0 -> REC_ARM.
  - sel_rise with mode_sel=1 and length≠0 -> PLAY, ram_addr<=0.
  - sel_rise with mode_sel=1 and length=0 -> stay in IDLE.
- REC_ARM:
  - sel_rise -> RECORDING; ram_addr<=0, latch_clr=1, length<=0.
  - back_rise -> IDLE.
- RECORDING:
  - latch_en=1 throughout.
  - On tick: ram_wren=1 and latch_clr=1 in the same cycle; ram_addr<=ram_addr+1; length<=length+1.
  - Tick at ram_addr=DEPTH-1: write, length<=DEPTH, ram_addr stays DEPTH-1, done=1 on the next cycle, -> IDLE.
  - sel_rise -> IDLE, done=1, length keeps the slots already written.
  - back_rise -> REC_ARM, length<=0 (take discarded).
- PLAY:
  - On tick: note_strobe=1 for ram_addr.
  - Tick with ram_addr=length-1 -> IDLE, done=1 on the next cycle, ram_addr unchanged.
  - Otherwise tick -> ram_addr<=ram_addr+1.
  - sel_rise or back_rise -> IDLE, no done.
- Simultaneous events:
  - tick and sel_rise in RECORDING: the tick write is performed, then stop. Length includes that slot.
  - tick and back_rise in RECORDING: back wins; no write, length<=0.
  - back_rise and sel_rise in the same cycle: back wins in every state.
- length is retained across takes and is cleared only by reset or the start of a new recording.

## Timing
- Reset: state=IDLE, ram_addr=0, length=0; ram_wren, latch_en, latch_clr, note_strobe, busy and done all 0. Edge-detect registers are cleared.
- Reset mid-operation aborts immediately with the same values. A key held through reset does not produce an edge on the first cycle after reset.
- ram_wren, latch_clr and note_strobe are combinational from state and tick: zero-cycle latency from tick.
- ram_addr, length and done are registered: they update at the edge after the triggering event.
- Play timing: ram_addr is stable for ≥3 cycles before each strobe, which covers the registered-address RAM's one-cycle read latency.
- The first play tick after entering PLAY strobes slot 0.

## Structure
- Shared package holds the state encoding localparams (IDLE=0, REC_ARM=1, RECORDING=2, PLAY=3), DEPTH and ADDR_W.
- Sub-module key_edge (one instance per key): edge detect plus reset.
- The FSM and counters stay in one module.

## Test plan
- Reset, then sel_rise with mode_sel=1 and length=0 -> stays in IDLE, busy=0.
- Record, select, select, then 5 ticks, then select -> 5 ram_wren pulses at addresses 0..4, latch_clr coincident with each, length=5, done pulse, IDLE.
- Record 64 ticks -> last write at address 63, length=64, done, IDLE; a 65th tick causes no write.
- Play after length=5, then 6 ticks -> note_strobe at addresses 0..4, done after the 5th, no strobe on the 6th tick.
- Tick and back_rise in the same cycle during RECORDING -> no ram_wren, length=0, state REC_ARM.
- resetn low for one cycle mid-PLAY with select held -> all outputs 0, IDLE, and no spurious transition after resetn rises.

Source files
------------

// File: rtl/note_seq_ctrl_pkg.sv
// Shared constants and state encoding for the note record/playback sequencer.
package note_seq_ctrl_pkg;

    localparam int unsigned DEPTH  = 64;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned LEN_W  = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_REC_ARM   = 2'd1,
        S_RECORDING = 2'd2,
        S_PLAY      = 2'd3
    } state_t;

endpackage

// File: rtl/note_seq_ctrl_if.sv
// Key/tick inputs and note-RAM/datapath control outputs of the sequencer.
interface note_seq_ctrl_if;
    import note_seq_ctrl_pkg::*;

    logic              tick;
    logic              select;
    logic              back;
    logic              mode_sel;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wren;
    logic              latch_en;
    logic              latch_clr;
    logic              note_strobe;
    logic [LEN_W-1:0]  length;
    logic              busy;
    logic              done;

    modport master (
        output tick, select, back, mode_sel,
        input  ram_addr, ram_wren, latch_en, latch_clr, note_strobe, length, busy, done
    );

    modport slave (
        input  tick, select, back, mode_sel,
        output ram_addr, ram_wren, latch_en, latch_clr, note_strobe, length, busy, done
    );

endinterface

// File: rtl/note_seq_ctrl_key_edge.sv
// Rising-edge detector for a debounced key; a key held through reset yields no edge.
module note_seq_ctrl_key_edge (
    input  logic clk,
    input  logic resetn,
    input  logic i_key,
    output logic o_rise_c
);

    logic r_key_q;
    logic r_armed;

    // r_armed masks the first cycle after reset, while r_key_q is still cleared
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_key_q <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_key_q <= i_key;
            r_armed <= 1'b1;
        end
    end

    assign o_rise_c = i_key & ~r_key_q & r_armed;

endmodule

// File: rtl/note_seq_ctrl.sv
// Record/playback sequencer: drives note RAM address/write and datapath latch control.
module note_seq_ctrl
    import note_seq_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    note_seq_ctrl_if.slave  bus
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;
    logic              r_done;

    logic w_sel_rise;
    logic w_back_rise;
    logic w_sel_go;
    logic w_rec_wr;
    logic w_arm_clr;
    logic w_last_play;
    logic w_last_slot;

    note_seq_ctrl_key_edge u_sel_edge (
        .clk      (clk),
        .resetn   (resetn),
        .i_key    (bus.select),
        .o_rise_c (w_sel_rise)
    );

    note_seq_ctrl_key_edge u_back_edge (
        .clk      (clk),
        .resetn   (resetn),
        .i_key    (bus.back),
        .o_rise_c (w_back_rise)
    );

    // back takes priority over select everywhere
    assign w_sel_go    = w_sel_rise & ~w_back_rise;
    assign w_rec_wr    = resetn & (r_state == S_RECORDING) & bus.tick & ~w_back_rise;
    assign w_arm_clr   = resetn & (r_state == S_REC_ARM) & w_sel_go;
    assign w_last_play = ({1'b0, r_addr} == (r_len - LEN_W'(1)));
    assign w_last_slot = (r_addr == ADDR_W'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_len   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_sel_go) begin
                        if (!bus.mode_sel) begin
                            r_state <= S_REC_ARM;
                        end else if (r_len != '0) begin
                            r_state <= S_PLAY;
                            r_addr  <= '0;
                        end
                    end
                end
                S_REC_ARM: begin
                    if (w_back_rise) begin
                        r_state <= S_IDLE;
                    end else if (w_sel_rise) begin
                        r_state <= S_RECORDING;
                        r_addr  <= '0;
                        r_len   <= '0;
                    end
                end
                S_RECORDING: begin
                    if (w_back_rise) begin
                        r_state <= S_REC_ARM;
                        r_len   <= '0;
                    end else begin
                        // a tick coinciding with select is still written before stopping
                        if (bus.tick) begin
                            r_len <= r_len + LEN_W'(1);
                            if (!w_last_slot) r_addr <= r_addr + ADDR_W'(1);
                        end
                        if (w_sel_rise || (bus.tick && w_last_slot)) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_PLAY: begin
                    if (w_sel_rise || w_back_rise) begin
                        r_state <= S_IDLE;
                    end else if (bus.tick) begin
                        if (w_last_play) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_addr <= r_addr + ADDR_W'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ram_addr    = r_addr;
    assign bus.ram_wren    = w_rec_wr;
    assign bus.latch_en    = (r_state == S_RECORDING);
    assign bus.latch_clr   = w_rec_wr | w_arm_clr;
    assign bus.note_strobe = resetn & (r_state == S_PLAY) & bus.tick;
    assign bus.length      = r_len;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = r_done;

endmodule

// File: tb/tb_note_seq_ctrl.sv
// Table-driven bench for note_seq_ctrl with a write/strobe address scoreboard.
module tb_note_seq_ctrl;
    import note_seq_ctrl_pkg::*;

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    note_seq_ctrl_if bus ();

    note_seq_ctrl u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        logic sel;
        logic bk;
        logic mode;
        logic tick;
        int   idle;
        logic e_wren;
        logic e_clr;
        logic e_stb;
        int   e_addr;
        int   e_len;
        logic e_done;
        logic e_busy;
        logic e_len_en;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;
    int   exp_addr = 0;
    int   q_wr[$];
    int   q_stb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic sel, input logic bk, input logic mode, input logic tick,
                                input int idle, input logic wren, input logic clr, input logic stb,
                                input int addr, input int len, input logic dn, input logic busy,
                                input logic le);
        vec_t v;
        v.sel = sel; v.bk = bk; v.mode = mode; v.tick = tick; v.idle = idle;
        v.e_wren = wren; v.e_clr = clr; v.e_stb = stb;
        v.e_addr = addr; v.e_len = len; v.e_done = dn; v.e_busy = busy; v.e_len_en = le;
        return v;
    endfunction

    // One cycle of stimulus: combinational outputs checked before the edge, registered after
    task automatic apply(input vec_t v);
        @(negedge clk);
        bus.select   = v.sel;
        bus.back     = v.bk;
        bus.mode_sel = v.mode;
        bus.tick     = v.tick;
        if (v.e_wren) q_wr.push_back(exp_addr);
        if (v.e_stb)  q_stb.push_back(exp_addr);
        #1;
        chk("ram_wren",    32'(bus.ram_wren),    32'(v.e_wren));
        chk("latch_clr",   32'(bus.latch_clr),   32'(v.e_clr));
        chk("note_strobe", 32'(bus.note_strobe), 32'(v.e_stb));
        @(posedge clk);
        #1;
        chk("ram_addr", 32'(bus.ram_addr), 32'(v.e_addr));
        chk("length",   32'(bus.length),   32'(v.e_len));
        chk("done",     32'(bus.done),     32'(v.e_done));
        chk("busy",     32'(bus.busy),     32'(v.e_busy));
        chk("latch_en", 32'(bus.latch_en), 32'(v.e_len_en));
        exp_addr = v.e_addr;
        for (int k = 0; k < v.idle; k++) begin
            @(negedge clk);
            bus.tick = 1'b0;
        end
    endtask

    // Scoreboard: every write/strobe pulse must match the next expected address
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (bus.ram_wren === 1'b1) begin
                if (q_wr.size() == 0) begin
                    total++; bad++;
                    $display("FAIL wren_unexpected: got write at addr %0d expected none", bus.ram_addr);
                end else begin
                    chk("wren_addr", 32'(bus.ram_addr), 32'(q_wr.pop_front()));
                end
            end
            if (bus.note_strobe === 1'b1) begin
                if (q_stb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL strobe_unexpected: got strobe at addr %0d expected none", bus.ram_addr);
                end else begin
                    chk("strobe_addr", 32'(bus.ram_addr), 32'(q_stb.pop_front()));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.select   = 1'b0;
        bus.back     = 1'b0;
        bus.mode_sel = 1'b0;
        bus.tick     = 1'b0;
        resetn       = 1'b0;

        //                  sel bk md tk idle wr cl st addr len dn bs le
        vecs.push_back(mk(1, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0)); // play with length 0 ignored
        vecs.push_back(mk(0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0)); // arm
        vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 1, 1)); // start recording
        vecs.push_back(mk(0, 0, 0, 0, 2,  0, 0, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 3,  1, 1, 0, 1, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 3,  1, 1, 0, 2, 2, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 3,  1, 1, 0, 3, 3, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 3,  1, 1, 0, 4, 4, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 3,  1, 1, 0, 5, 5, 0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 5, 5, 1, 0, 0)); // stop, done
        vecs.push_back(mk(0, 0, 1, 0, 0,  0, 0, 0, 5, 5, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0,  0, 0, 0, 0, 5, 0, 1, 0)); // play
        vecs.push_back(mk(0, 0, 1, 0, 2,  0, 0, 0, 0, 5, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 3,  0, 0, 1, 1, 5, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 3,  0, 0, 1, 2, 5, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 3,  0, 0, 1, 3, 5, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 3,  0, 0, 1, 4, 5, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 3,  0, 0, 1, 4, 5, 1, 0, 0)); // last slot, done
        vecs.push_back(mk(0, 0, 1, 1, 3,  0, 0, 0, 4, 5, 0, 0, 0)); // 6th tick: no strobe
        vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 4, 5, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 4, 5, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 1, 1)); // new take clears length
        vecs.push_back(mk(0, 0, 0, 0, 2,  0, 0, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 3,  1, 1, 0, 1, 1, 0, 1, 1));
        vecs.push_back(mk(0, 1, 0, 1, 0,  0, 0, 0, 1, 0, 0, 1, 0)); // tick+back: back wins
        vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0)); // sel+back in arm: back wins
        vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 2,  0, 0, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 3,  1, 1, 0, 1, 1, 0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 1, 0,  1, 1, 0, 2, 2, 1, 0, 0)); // tick+sel: write then stop
        vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 2, 2, 0, 0, 0));

        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr",   32'(bus.ram_addr),    32'd0);
        chk("rst_length", 32'(bus.length),      32'd0);
        chk("rst_busy",   32'(bus.busy),        32'd0);
        chk("rst_done",   32'(bus.done),        32'd0);
        chk("rst_wren",   32'(bus.ram_wren),    32'd0);
        chk("rst_latch",  32'(bus.latch_en),    32'd0);
        chk("rst_clr",    32'(bus.latch_clr),   32'd0);
        chk("rst_strobe", 32'(bus.note_strobe), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        foreach (vecs[i]) apply(vecs[i]);

        // Full 64-slot take, then a tick in IDLE must not write
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0, 1, 0));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0, 1, 0));
        apply(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1));
        apply(mk(0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 1, 1));
        for (int i = 0; i < 64; i++) begin
            apply(mk(0, 0, 0, 1, 3, 1, 1, 0, (i < 63) ? i + 1 : 63, i + 1,
                     logic'(i == 63), logic'(i < 63), logic'(i < 63)));
        end
        apply(mk(0, 0, 0, 1, 3, 0, 0, 0, 63, 64, 0, 0, 0));

        // Reset mid-PLAY with select held across it
        apply(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 64, 0, 1, 0));
        apply(mk(0, 0, 1, 0, 2, 0, 0, 0, 0, 64, 0, 1, 0));
        apply(mk(0, 0, 1, 1, 3, 0, 0, 1, 1, 64, 0, 1, 0));
        @(negedge clk);
        resetn       = 1'b0;
        bus.select   = 1'b1;
        bus.mode_sel = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_addr",   32'(bus.ram_addr), 32'd0);
        chk("midrst_length", 32'(bus.length),   32'd0);
        chk("midrst_busy",   32'(bus.busy),     32'd0);
        chk("midrst_done",   32'(bus.done),     32'd0);
        chk("midrst_latch",  32'(bus.latch_en), 32'd0);
        exp_addr = 0;
        @(negedge clk);
        resetn = 1'b1;
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // held key: no edge after reset
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)); // fresh press still arms

        repeat (2) @(negedge clk);
        chk("wr_queue_left",  32'(q_wr.size()),  32'd0);
        chk("stb_queue_left", 32'(q_stb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
